// File: rtl/run_seq_pkg.sv
// Shared types and constants for the program run sequencer.
package run_seq_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} seqState_t;
  localparam int PROG_W    = 2;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Up-counter with synchronous clear, saturating at all-ones, plus terminal compare.
// One-cycle update latency; no backpressure, counts only while en is high.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] termVal,
  output logic [W-1:0] q,
  output logic         atTerm
);
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

  assign atTerm = (q == termVal);
endmodule

// File: rtl/run_sequencer.sv
// Launches core programs (singly or all in sequence), times each run until Ack or timeout.
// Start rises one cycle after a request; requests while busy are dropped, never queued.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int               NUM_PROGS = 3,
  parameter int               CNT_W     = CNT_W_DEF,
  parameter int               START_LEN = 2,
  parameter logic [CNT_W-1:0] TIMEOUT   = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              req_all,
  input  logic [PROG_W-1:0] req_prog,
  output logic              Start,
  input  logic              Ack,
  output logic [PROG_W-1:0] prog_sel,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic              bad_req,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int                LW         = $clog2(START_LEN + 1);
  localparam logic [LW-1:0]     LAUNCH_END = LW'(START_LEN - 1);
  localparam logic [PROG_W:0]   NPROGS     = (PROG_W + 1)'(NUM_PROGS);
  localparam logic [PROG_W-1:0] LAST_PROG  = PROG_W'(NUM_PROGS - 1);

  seqState_t        state;
  logic             allMode;
  logic             launchEnd;
  logic             runTimeout;
  logic [LW-1:0]    unusedLaunchCnt;
  logic [CNT_W-1:0] execCnt;

  sat_counter #(.W(LW)) launchCounter (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (state != LAUNCH),
    .en      (state == LAUNCH),
    .termVal (LAUNCH_END),
    .q       (unusedLaunchCnt),
    .atTerm  (launchEnd)
  );

  // Terminal is one below TIMEOUT: the cycle that would bring the count to TIMEOUT ends the run.
  sat_counter #(.W(CNT_W)) execCounter (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (state != RUN),
    .en      ((state == RUN) && !Ack),
    .termVal (TIMEOUT - CNT_W'(1)),
    .q       (execCnt),
    .atTerm  (runTimeout)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      allMode     <= 1'b0;
      Start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      bad_req     <= 1'b0;
      prog_sel    <= '0;
      cycle_count <= '0;
    end else begin
      done    <= 1'b0;
      bad_req <= 1'b0;
      case (state)
        IDLE: begin
          if (req_all) begin
            prog_sel <= '0;
            allMode  <= 1'b1;
            Start    <= 1'b1;
            busy     <= 1'b1;
            state    <= LAUNCH;
          end else if (req) begin
            if ({1'b0, req_prog} < NPROGS) begin
              prog_sel <= req_prog;
              allMode  <= 1'b0;
              Start    <= 1'b1;
              busy     <= 1'b1;
              state    <= LAUNCH;
            end else begin
              bad_req <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (launchEnd) begin
            Start <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (Ack) begin
            cycle_count <= execCnt;
            timed_out   <= 1'b0;
            done        <= 1'b1;
            state       <= REPORT;
          end else if (runTimeout) begin
            cycle_count <= TIMEOUT;
            timed_out   <= 1'b1;
            done        <= 1'b1;
            state       <= REPORT;
          end
        end
        REPORT: begin
          if (allMode && (prog_sel < LAST_PROG)) begin
            prog_sel <= prog_sel + PROG_W'(1);
            Start    <= 1'b1;
            state    <= LAUNCH;
          end else begin
            allMode <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Sequences program execution on the single-cycle core. On a host request it selects a program and drives the core's Start for a fixed number of cycles. It then counts execution cycles until the core raises Ack, or until a timeout, and reports the result. It sits between the testbench/host and TopLevel's Start/Ack pins, and also supports a back-to-back "run all programs" mode.

Parameters:
NUM_PROGS, 3, number of programs resident in instruction ROM (1..4)
CNT_W, 16, width of the execution cycle counter
START_LEN, 2, cycles Start is held high per launch (>=1)
TIMEOUT, 16'hFFFF, RUN cycles allowed before abort (<= 2**CNT_W-1)

Ports:
Clk  input  1  clock; all logic on posedge
Reset  input  1  synchronous, active-high reset
req  input  1  single-program launch request, sampled in IDLE only
req_all  input  1  launch programs 0..NUM_PROGS-1 in sequence, sampled in IDLE only
req_prog  input  2  program index for req
Start  output  1  to core: start/init next program
Ack  input  1  from core: program halted
prog_sel  output  2  program index currently selected (to InstFetch base select)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse per completed program (normal or timeout)
timed_out  output  1  valid with done: program hit TIMEOUT
bad_req  output  1  one-cycle pulse: req with req_prog >= NUM_PROGS
cycle_count  output  CNT_W  RUN-cycle count of the last finished program, held until next done

Behaviour:
- Reset (synchronous, Reset=1 at posedge): state=IDLE; Start, busy, done, timed_out and bad_req = 0; prog_sel = 0; cycle_count = 0; internal counters cleared. Applies mid-run: Start drops on the next edge, and the interrupted program's count is discarded.
- States: IDLE, LAUNCH, RUN, REPORT.
- IDLE:
  - req_all=1 → prog_sel=0, all_mode=1, go to LAUNCH.
  - Otherwise req=1 with req_prog<NUM_PROGS → prog_sel=req_prog, all_mode=0, go to LAUNCH.
  - req=1 with req_prog>=NUM_PROGS → bad_req pulses 1 cycle; stay IDLE.
  - req_all has priority over req.
- LAUNCH: Start=1 for exactly START_LEN cycles (launch counter), then go to RUN. Ack is ignored in LAUNCH because the core is initialising.
- RUN:
  - Start=0; exec counter starts at 0.
  - Each cycle with Ack=0: counter +1, saturating at 2**CNT_W-1.
  - First cycle with Ack=1: cycle_count←counter, timed_out←0, go to REPORT.
  - If counter reaches TIMEOUT with Ack still 0: cycle_count←TIMEOUT, timed_out←1, go to REPORT.
  - Ack=1 in the very first RUN cycle gives cycle_count=0.
- REPORT (1 cycle): done=1.
  - Next state is LAUNCH with prog_sel+1 if all_mode and prog_sel<NUM_PROGS-1.
  - Otherwise next state is IDLE, and all_mode clears.
  - In all_mode, a timeout does not stop the sequence.
- Latency: req sampled at edge N → Start high from edge N+1 for START_LEN cycles → first RUN cycle at N+1+START_LEN.
- req/req_all while busy are ignored (no queueing); bad_req is not raised while busy.
- prog_sel is stable from LAUNCH entry through REPORT.
- Outputs are registered; done, timed_out and cycle_count change only on the REPORT entry edge.

Decomposition:
- Shared package run_seq_pkg: state enum (IDLE, LAUNCH, RUN, REPORT), PROG_W=2, default CNT_W.
- One natural sub-module: sat_counter (clear, enable, saturate at max, terminal-value compare). It is instantiated twice: launch counter and exec counter.

Test Plan:
- Reset, then req=1, req_prog=1, START_LEN=2, Ack rises on the 37th RUN cycle → Start high for exactly 2 cycles; prog_sel=1; done pulse 1 cycle; cycle_count=36; timed_out=0.
- req_all=1 with NUM_PROGS=3, Acks after 10/20/30 RUN cycles → three done pulses with prog_sel 0,1,2 and cycle_count 10,20,30; three Start bursts; busy low only after the third REPORT.
- TIMEOUT=100, Ack held 0 → done after 100 RUN cycles; timed_out=1; cycle_count=100; return to IDLE.
- req=1, req_prog=3, NUM_PROGS=3 → bad_req pulses once; Start never asserts; busy stays 0. Then req during RUN → ignored, and the running program's count is unaffected.
- Ack=1 held through LAUNCH and into RUN → ignored during LAUNCH; done on the first RUN cycle with cycle_count=0.
- Reset asserted on RUN cycle 5 → next edge: IDLE, Start=0, busy=0, cycle_count=0, no done pulse.
